cache_miss_ctrl: RTL
====================

Name: cache_miss_ctrl

Overview:
- Miss/replacement controller placed directly downstream of the per-set LRU tracker in the L1 caches.
- On a miss it selects a victim way. That is the lowest invalid way if any exists, otherwise the LRU way.
- Handles the victim: issues a writeback request for a dirty victim, then a refill request, then commits the new tag to the tag array.
- Owns the single LRU read/update port; arbitrates hit-driven LRU updates against fill-driven updates.

Parameters:
ASSOCIATIVITY, 4, number of ways (power of two, >=2)
ENTRIES, 256, sets per way
INDEX_BITS, 8, log2(ENTRIES)
WAY_BITS, 2, log2(ASSOCIATIVITY)
TAG_BITS, 20, tag width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
hit_valid  in  1  lookup hit, request LRU touch
hit_ready  out  1  hit touch accepted this cycle
hit_index  in  INDEX_BITS  set of hit
hit_way  in  WAY_BITS  way of hit
miss_valid  in  1  miss request
miss_ready  out  1  miss accepted (IDLE only)
miss_index  in  INDEX_BITS  set of miss
miss_tag  in  TAG_BITS  tag of missing line
lru_line_selector  out  INDEX_BITS  LRU read/update set
lru_way  in  WAY_BITS  LRU way for lru_line_selector (combinational)
lru_update  out  1  LRU update strobe
lru_referenced_set  out  WAY_BITS  way being referenced
set_valid  in  ASSOCIATIVITY  valid bits of set miss_index_q (combinational tag-array read)
set_dirty  in  ASSOCIATIVITY  dirty bits of same set
set_tags  in  ASSOCIATIVITY*TAG_BITS  tags of same set, way w at [w*TAG_BITS +: TAG_BITS]
tag_rd_index  out  INDEX_BITS  tag-array read index (= miss_index_q)
wb_valid/wb_ready  out/in  1  writeback request handshake
wb_index, wb_way, wb_tag  out  INDEX_BITS/WAY_BITS/TAG_BITS  victim location and old tag
refill_valid/refill_ready  out/in  1  refill request handshake
refill_index, refill_way, refill_tag  out  INDEX_BITS/WAY_BITS/TAG_BITS  target location and new tag
refill_done  in  1  single-cycle pulse: line data written into the data array
fill_valid  out  1  single-cycle tag commit: set valid, clear dirty
fill_index, fill_way, fill_tag  out  INDEX_BITS/WAY_BITS/TAG_BITS  commit fields

Behaviour:
- State machine: IDLE, SELECT, WB_REQ, RF_REQ, RF_WAIT, FILL.
- Reset: state=IDLE.
  - All *_valid outputs, fill_valid and lru_update are 0.
  - Latched index/tag/way registers are 0.
  - miss_ready=1 after reset release.
- Reset asserted mid-operation abandons the miss with no writeback or fill emitted; the requester must re-issue.
- IDLE:
  - miss_ready=1.
  - miss_valid&miss_ready latches miss_index_q/miss_tag_q and moves to SELECT.
- SELECT (exactly 1 cycle):
  - lru_line_selector=miss_index_q.
  - Victim = lowest w with set_valid[w]=0, else lru_way; latched into way_q.
  - Also latched: victim_tag_q = set_tags[way_q], need_wb = set_valid[way_q]&set_dirty[way_q].
  - Next state is WB_REQ if need_wb, else RF_REQ.
- WB_REQ:
  - wb_valid=1, with fields stable until wb_ready.
  - Handshake moves to RF_REQ.
- RF_REQ:
  - refill_valid=1, with fields stable until refill_ready.
  - Handshake moves to RF_WAIT.
  - A refill is never issued before the writeback handshake completes.
- RF_WAIT: waits for refill_done. A refill_done seen in any other state is ignored.
- FILL (exactly 1 cycle):
  - fill_valid=1 with fill_index=miss_index_q, fill_way=way_q, fill_tag=miss_tag_q.
  - lru_update=1, lru_line_selector=miss_index_q, lru_referenced_set=way_q.
  - Next state IDLE.
- Miss latency: total miss latency without stalls = 1 (SELECT) + wb + refill + 1 (FILL).
- Hit touches:
  - hit_ready = 1 in every state except SELECT and FILL.
  - When hit_valid&hit_ready: lru_update=1, lru_line_selector=hit_index, lru_referenced_set=hit_way, all in the same cycle (combinational).
  - In SELECT and FILL, a held hit stalls; it is never dropped.
- When no update is active, lru_line_selector=hit_index outside SELECT/FILL.
- Only one miss is outstanding at a time; miss_ready=0 outside IDLE.
- A hit to the victim set while the miss is in flight is legal and updates the LRU. The victim way is already latched and does not change.

Decomposition:
- Package cache_miss_pkg holds:
  - the state enum miss_state_e (6 states, 3 bits);
  - localparam helpers for WAY_BITS = $clog2(ASSOCIATIVITY).
- Sub-module victim_select: combinational; inputs set_valid, lru_way; outputs victim way and any_invalid. It uses a priority encoder over the invalid ways.

Test Plan:
1. Reset, then a miss with index 0x12, tag 0xABCDE, set_valid=4'b1011 -> victim way 2, no wb; refill_index=0x12, refill_way=2; after refill_done, fill_valid pulses 1 cycle and lru_update with referenced_set=2.
2. Full set (valid=4'hF, dirty=4'b0001), lru_way=0, set_tags[0]=0x00111 -> wb_valid with wb_way=0, wb_tag=0x00111; hold wb_ready=0 for 5 cycles and check fields stay stable and refill_valid=0; then the refill follows.
3. Full clean set, lru_way=3 -> no wb_valid, refill_way=3; total latency with refill_ready=1 and refill_done 4 cycles later is 7 cycles from miss accept to fill_valid.
4. hit_valid held from the SELECT cycle -> hit_ready=0 in SELECT and FILL, 1 elsewhere; exactly one lru_update per accepted hit, with hit_index/hit_way on the LRU port.
5. Assert rst_n low in RF_WAIT -> all outputs 0 immediately; after release, miss_ready=1 and a late refill_done is ignored (no fill_valid).
6. miss_valid in a non-IDLE state -> miss_ready=0 and the request is not latched until IDLE; back-to-back misses are accepted on the cycle after FILL.

Source files
------------

// File: rtl/cache_miss_pkg.sv
// Shared types and default geometry for the L1 miss/replacement controller.
package cache_miss_pkg;

  localparam int DEF_ASSOCIATIVITY = 4;
  localparam int DEF_ENTRIES       = 256;
  localparam int DEF_INDEX_BITS    = $clog2(DEF_ENTRIES);
  localparam int DEF_WAY_BITS      = $clog2(DEF_ASSOCIATIVITY);
  localparam int DEF_TAG_BITS      = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    WB_REQ  = 3'd2,
    RF_REQ  = 3'd3,
    RF_WAIT = 3'd4,
    FILL    = 3'd5
  } miss_state_e;

  function automatic int way_bits(input int assoc);
    return $clog2(assoc);
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_victim_select.sv
// Victim choice: lowest invalid way of the set, else the LRU way.
module victim_select
  import cache_miss_pkg::*;
#(
  parameter int ASSOCIATIVITY = DEF_ASSOCIATIVITY,
  parameter int WAY_BITS      = way_bits(DEF_ASSOCIATIVITY)
) (
  input  logic [ASSOCIATIVITY-1:0] set_valid,
  input  logic [WAY_BITS-1:0]      lru_way,
  output logic [WAY_BITS-1:0]      victim_way,
  output logic                     any_invalid
);

  logic [WAY_BITS-1:0] first_invalid;

  // Scan from the top so the lowest invalid way wins.
  always_comb begin
    first_invalid = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!set_valid[w]) first_invalid = WAY_BITS'(w);
    end
  end

  assign any_invalid = ~&set_valid;
  assign victim_way  = any_invalid ? first_invalid : lru_way;

endmodule

// File: rtl/cache_miss_ctrl.sv
// L1 miss controller: victim selection, writeback, refill, tag commit,
// and arbitration of the shared LRU update port between hits and fills.
module cache_miss_ctrl
  import cache_miss_pkg::*;
#(
  parameter int ASSOCIATIVITY = DEF_ASSOCIATIVITY,
  parameter int ENTRIES       = DEF_ENTRIES,
  parameter int INDEX_BITS    = $clog2(ENTRIES),
  parameter int WAY_BITS      = way_bits(ASSOCIATIVITY),
  parameter int TAG_BITS      = DEF_TAG_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              hit_valid,
  output logic                              hit_ready,
  input  logic [INDEX_BITS-1:0]             hit_index,
  input  logic [WAY_BITS-1:0]               hit_way,
  input  logic                              miss_valid,
  output logic                              miss_ready,
  input  logic [INDEX_BITS-1:0]             miss_index,
  input  logic [TAG_BITS-1:0]               miss_tag,
  output logic [INDEX_BITS-1:0]             lru_line_selector,
  input  logic [WAY_BITS-1:0]               lru_way,
  output logic                              lru_update,
  output logic [WAY_BITS-1:0]               lru_referenced_set,
  input  logic [ASSOCIATIVITY-1:0]          set_valid,
  input  logic [ASSOCIATIVITY-1:0]          set_dirty,
  input  logic [ASSOCIATIVITY*TAG_BITS-1:0] set_tags,
  output logic [INDEX_BITS-1:0]             tag_rd_index,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [INDEX_BITS-1:0]             wb_index,
  output logic [WAY_BITS-1:0]               wb_way,
  output logic [TAG_BITS-1:0]               wb_tag,
  output logic                              refill_valid,
  input  logic                              refill_ready,
  output logic [INDEX_BITS-1:0]             refill_index,
  output logic [WAY_BITS-1:0]               refill_way,
  output logic [TAG_BITS-1:0]               refill_tag,
  input  logic                              refill_done,
  output logic                              fill_valid,
  output logic [INDEX_BITS-1:0]             fill_index,
  output logic [WAY_BITS-1:0]               fill_way,
  output logic [TAG_BITS-1:0]               fill_tag
);

  miss_state_e state_q, state_d;

  logic [INDEX_BITS-1:0] miss_index_q;
  logic [TAG_BITS-1:0]   miss_tag_q;
  logic [WAY_BITS-1:0]   way_q;
  logic [TAG_BITS-1:0]   victim_tag_q;

  logic [WAY_BITS-1:0]   victim_way;
  logic                  any_invalid;
  logic                  need_wb;
  logic                  ready_ok;
  logic [TAG_BITS-1:0]   tag_arr [ASSOCIATIVITY];

  genvar gi;
  generate
    for (gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_tag_unpack
      assign tag_arr[gi] = set_tags[gi*TAG_BITS +: TAG_BITS];
    end
  endgenerate

  victim_select #(
    .ASSOCIATIVITY(ASSOCIATIVITY),
    .WAY_BITS     (WAY_BITS)
  ) u_victim_select (
    .set_valid  (set_valid),
    .lru_way    (lru_way),
    .victim_way (victim_way),
    .any_invalid(any_invalid)
  );

  // An invalid victim never needs a writeback, so any_invalid short-circuits it.
  assign need_wb = !any_invalid && set_valid[victim_way] && set_dirty[victim_way];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
      way_q        <= '0;
      victim_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && miss_valid) begin
        miss_index_q <= miss_index;
        miss_tag_q   <= miss_tag;
      end
      if (state_q == SELECT) begin
        way_q        <= victim_way;
        victim_tag_q <= tag_arr[victim_way];
      end
    end
  end

  // Readies are held low while reset is asserted so nothing is accepted then.
  assign ready_ok = rst_n;

  always_comb begin
    state_d      = state_q;
    miss_ready   = 1'b0;
    hit_ready    = 1'b0;
    wb_valid     = 1'b0;
    refill_valid = 1'b0;
    fill_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready = ready_ok;
        hit_ready  = ready_ok;
        if (miss_valid && ready_ok) state_d = SELECT;
      end
      SELECT: begin
        state_d = need_wb ? WB_REQ : RF_REQ;
      end
      WB_REQ: begin
        hit_ready = ready_ok;
        wb_valid  = 1'b1;
        if (wb_ready) state_d = RF_REQ;
      end
      RF_REQ: begin
        hit_ready    = ready_ok;
        refill_valid = 1'b1;
        if (refill_ready) state_d = RF_WAIT;
      end
      RF_WAIT: begin
        hit_ready = ready_ok;
        if (refill_done) state_d = FILL;
      end
      FILL: begin
        fill_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hits own the LRU port except in SELECT (victim read) and FILL (commit).
  always_comb begin
    lru_update         = fill_valid | (hit_valid & hit_ready);
    lru_line_selector  = hit_index;
    lru_referenced_set = hit_way;
    if (state_q == SELECT || state_q == FILL) lru_line_selector = miss_index_q;
    if (state_q == FILL) lru_referenced_set = way_q;
  end

  assign tag_rd_index = miss_index_q;
  assign wb_index     = miss_index_q;
  assign wb_way       = way_q;
  assign wb_tag       = victim_tag_q;
  assign refill_index = miss_index_q;
  assign refill_way   = way_q;
  assign refill_tag   = miss_tag_q;
  assign fill_index   = miss_index_q;
  assign fill_way     = way_q;
  assign fill_tag     = miss_tag_q;

endmodule
